// File: rtl/ram_burst_reader_if.sv
// Bundles the control, RAM read-port and output-stream signals of the
// burst reader. The reader uses the master view; its environment uses slave.
interface ram_burst_reader_if #(
    parameter int ADDRWIDTH = 16,
    parameter int DATAWIDTH = 256,
    parameter int LENWIDTH  = ADDRWIDTH + 1
);
    logic                 start;
    logic [ADDRWIDTH-1:0] base_addr;
    logic [LENWIDTH-1:0]  burst_len;
    logic                 busy;
    logic                 done;
    logic [ADDRWIDTH-1:0] ram_addr;
    logic                 ram_read_enable;
    logic [DATAWIDTH-1:0] ram_data;
    logic [DATAWIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        input  start, base_addr, burst_len, ram_data, out_ready,
        output busy, done, ram_addr, ram_read_enable, out_data, out_valid
    );

    modport slave (
        output start, base_addr, burst_len, ram_data, out_ready,
        input  busy, done, ram_addr, ram_read_enable, out_data, out_valid
    );
endinterface

// File: rtl/ram_burst_reader.sv
// Burst read engine for the display RAM: issues sequential reads, tracks the
// fixed RAM latency with a tag pipe and hands words out through a small
// first-word-fall-through FIFO. Reads are only issued when every word already
// requested has a guaranteed FIFO slot, so a stalled consumer never loses data.
//
// state | meaning
// IDLE  | waiting for start; a zero-length start just pulses done
// ISSUE | issuing reads while credit allows, until all words requested
// DRAIN | all reads issued; waiting for returns and for the FIFO to empty
module ram_burst_reader #(
    parameter int ADDRWIDTH  = 16,
    parameter int DATAWIDTH  = 256,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int LENWIDTH   = ADDRWIDTH + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    ram_burst_reader_if.master bus
);
    localparam int PTRW = $clog2(FIFO_DEPTH);
    localparam int CNTW = PTRW + 1;
    localparam logic [CNTW:0] DEPTH_C = (CNTW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 done_r;
    logic                 done_next;
    logic                 strobe;
    logic                 credit_ok;
    logic [ADDRWIDTH-1:0] cur_addr;
    logic [LENWIDTH-1:0]  remaining;
    logic [LATENCY-1:0]   tag_pipe;
    logic [CNTW-1:0]      inflight;
    logic [CNTW-1:0]      fifo_count;
    logic [PTRW-1:0]      wr_ptr;
    logic [PTRW-1:0]      rd_ptr;
    logic [DATAWIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic                 push;
    logic                 pop;

    // Credit uses registered counts only, so a pop this cycle frees a slot next cycle.
    assign credit_ok = ({1'b0, inflight} + {1'b0, fifo_count}) < DEPTH_C;
    assign push      = tag_pipe[LATENCY-1];
    assign pop       = (fifo_count != '0) && bus.out_ready;

    // Next-state, read strobe and done request.
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        strobe     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.burst_len == '0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (credit_ok) begin
                    strobe = 1'b1;
                    if (remaining == LENWIDTH'(1)) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((inflight == '0) && (fifo_count == '0)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register and registered done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            done_r <= 1'b0;
        end else begin
            state  <= state_next;
            done_r <= done_next;
        end
    end

    // Address and remaining-word counters: captured on start, stepped per strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_addr  <= '0;
            remaining <= '0;
        end else if ((state == IDLE) && bus.start) begin
            cur_addr  <= bus.base_addr;
            remaining <= bus.burst_len;
        end else if (strobe) begin
            cur_addr  <= cur_addr + 1'b1;
            remaining <= remaining - 1'b1;
        end
    end

    // Return tags follow each strobe through the RAM latency; inflight counts them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_pipe <= '0;
            inflight <= '0;
        end else begin
            tag_pipe[0] <= strobe;
            for (int i = 1; i < LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
            case ({strobe, push})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    // Output skid FIFO; head is presented combinationally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= bus.ram_data;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign bus.busy            = (state != IDLE);
    assign bus.done            = done_r;
    assign bus.ram_addr        = cur_addr;
    assign bus.ram_read_enable = strobe;
    assign bus.out_data        = fifo_mem[rd_ptr];
    assign bus.out_valid       = (fifo_count != '0);
endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader: a behavioural RAM with fixed read
// latency, a scoreboard of expected strobe addresses and stream words, and a
// credit monitor that bounds outstanding reads by the FIFO depth.
module tb_ram_burst_reader;
    localparam int AW  = 16;
    localparam int DW  = 256;
    localparam int LAT = 2;
    localparam int FD  = 4;
    localparam int LW  = AW + 1;

    logic clk;
    logic reset_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    ram_burst_reader_if #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .LENWIDTH(LW)) bus ();

    ram_burst_reader #(
        .ADDRWIDTH(AW), .DATAWIDTH(DW), .LATENCY(LAT), .FIFO_DEPTH(FD), .LENWIDTH(LW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: word[a] = a, valid LAT edges after the strobe; not reset.
    logic [AW-1:0] rp_addr [LAT];
    logic          rp_vld  [LAT];
    always @(posedge clk) begin
        rp_vld[0]  <= bus.ram_read_enable;
        rp_addr[0] <= bus.ram_addr;
        for (int i = 1; i < LAT; i++) begin
            rp_vld[i]  <= rp_vld[i-1];
            rp_addr[i] <= rp_addr[i-1];
        end
    end
    assign bus.ram_data = (rp_vld[LAT-1] === 1'b1) ? DW'(rp_addr[LAT-1]) : {8{32'hDEADBEEF}};

    function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
        return DW'(a);
    endfunction

    logic [DW-1:0] exp_q [$];
    logic [AW-1:0] addr_q [$];
    int strobe_total = 0;
    int hs_total     = 0;
    int lost         = 0;
    int start_cyc    = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [LW-1:0] l, input bit accept);
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.base_addr = b;
        bus.burst_len = l;
        if (accept) begin
            for (int i = 0; i < int'(l); i++) begin
                exp_q.push_back(word_of(AW'(int'(b) + i)));
                addr_q.push_back(AW'(int'(b) + i));
            end
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, DW'(seen), DW'(1));
        check({tag, "_busy_at_done"}, DW'(bus.busy), DW'(0));
        check({tag, "_words_left"}, DW'(exp_q.size()), DW'(0));
        check({tag, "_strobes_left"}, DW'(addr_q.size()), DW'(0));
        @(negedge clk);
        check({tag, "_done_one_cycle"}, DW'(bus.done), DW'(0));
    endtask

    initial begin
        int n;
        int mark;
        bit hit;
        reset_n       = 1'b0;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.burst_len = '0;
        bus.out_ready = 1'b1;

        // Scoreboard/credit monitor, sampling on the falling edge.
        fork
            forever begin
                @(negedge clk);
                if (reset_n === 1'b1) begin
                    if (bus.ram_read_enable === 1'b1) begin
                        check("credit", DW'((strobe_total - hs_total - lost) < FD), DW'(1));
                        check("strobe_expected", DW'(addr_q.size() != 0), DW'(1));
                        if (addr_q.size() != 0) check("strobe_addr", DW'(bus.ram_addr), DW'(addr_q.pop_front()));
                        strobe_total++;
                    end
                    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                        check("word_expected", DW'(exp_q.size() != 0), DW'(1));
                        if (exp_q.size() != 0) check("word_data", bus.out_data, exp_q.pop_front());
                        hs_total++;
                    end
                end
            end
        join_none

        #23;
        check("rst_busy", DW'(bus.busy), DW'(0));
        check("rst_done", DW'(bus.done), DW'(0));
        check("rst_rd_en", DW'(bus.ram_read_enable), DW'(0));
        check("rst_valid", DW'(bus.out_valid), DW'(0));
        check("rst_addr", DW'(bus.ram_addr), DW'(0));
        check("rst_data", bus.out_data, DW'(0));
        @(posedge clk); #1;
        reset_n = 1'b1;

        // 1: basic burst, latency and full-rate stream.
        do_start(16'h0010, 17'd8, 1'b1);
        check("t1_busy", DW'(bus.busy), DW'(1));
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                hit = 1'b1;
                break;
            end
        end
        check("t1_first_valid_seen", DW'(hit), DW'(1));
        check("t1_first_latency", DW'(cyc - start_cyc), DW'(LAT + 1));
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            check("t1_full_rate", DW'(bus.out_valid), DW'(1));
        end
        wait_done("t1", 30);

        // 2: address wrap at the top of the address space.
        do_start(16'hFFFE, 17'd4, 1'b1);
        wait_done("t2", 40);

        // 3: consumer stall mid-burst.
        do_start(16'h0040, 17'd16, 1'b1);
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 mark = strobe_total;
        repeat (5) @(posedge clk);
        #1;
        check("t3_stall_no_strobes", DW'(strobe_total - mark), DW'(0));
        check("t3_stall_outstanding", DW'(strobe_total - hs_total - lost), DW'(FD));
        check("t3_stall_valid", DW'(bus.out_valid), DW'(1));
        bus.out_ready = 1'b1;
        wait_done("t3", 80);

        // 4: zero-length burst.
        mark = strobe_total;
        do_start(16'h1234, 17'd0, 1'b1);
        check("t4_done", DW'(bus.done), DW'(1));
        check("t4_busy", DW'(bus.busy), DW'(0));
        @(posedge clk); #1;
        check("t4_done_cleared", DW'(bus.done), DW'(0));
        check("t4_busy_low", DW'(bus.busy), DW'(0));
        repeat (3) @(posedge clk);
        #1 check("t4_no_strobes", DW'(strobe_total - mark), DW'(0));

        // 5: start while busy is ignored.
        mark = hs_total;
        do_start(16'h0200, 17'd8, 1'b1);
        @(posedge clk);
        do_start(16'h0300, 17'd4, 1'b0);
        wait_done("t5", 60);
        check("t5_word_count", DW'(hs_total - mark), DW'(8));

        // 6: asynchronous reset mid-burst, then a fresh burst.
        do_start(16'h0500, 17'd8, 1'b1);
        n = 0;
        for (int i = 0; i < 20 && n < 3; i++) begin
            @(negedge clk);
            if (bus.ram_read_enable === 1'b1) n++;
        end
        check("t6_three_strobes", DW'(n), DW'(3));
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("t6_rst_busy", DW'(bus.busy), DW'(0));
        check("t6_rst_done", DW'(bus.done), DW'(0));
        check("t6_rst_rd_en", DW'(bus.ram_read_enable), DW'(0));
        check("t6_rst_valid", DW'(bus.out_valid), DW'(0));
        check("t6_rst_addr", DW'(bus.ram_addr), DW'(0));
        check("t6_rst_data", bus.out_data, DW'(0));
        exp_q.delete();
        addr_q.delete();
        lost = strobe_total - hs_total;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("t6_no_done_after_reset", DW'(bus.done), DW'(0));
        check("t6_no_valid_after_reset", DW'(bus.out_valid), DW'(0));
        mark = hs_total;
        do_start(16'h0100, 17'd2, 1'b1);
        wait_done("t6", 30);
        check("t6_word_count", DW'(hs_total - mark), DW'(2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
